// File: rtl/arm_mc_main_fsm.sv
// ---------------------------------------------------------------------------
// arm_mc_main_fsm
//
// Main-decoder state machine of the multicycle ARM datapath.
// Each instruction is sequenced through fetch, decode, execute, memory and
// writeback. The block drives the datapath mux selects and write enables, and
// the ALUop bit consumed by the downstream ALU decoder. A memory-ready
// handshake lets fetch and data accesses stall.
//
// Handshake: mem_ready is a level from the memory. It means "the access
// presented this cycle completes this cycle". FETCH, MEMREAD and MEMWRITE hold
// their state (and keep presenting the access) until mem_ready is seen high.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset (forces FETCH)
//   op          instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 undef
//   funct       instr[25:20]: [5] I, [4:1] cmd, [0] S/L
//   mem_ready   memory completes the current access this cycle
//   IRWrite     load instruction register
//   NextPC      PC update request
//   AdrSrc      memory address select (0 PC, 1 Result)
//   ALUSrcA     0 A register, 1 PC
//   ALUSrcB     00 WriteData, 01 ExtImm, 10 constant 4
//   ResultSrc   00 ALUOut, 01 Data, 10 ALUResult
//   ALUop       1 decode funct_cmd, 0 forced ADD
//   RegW        register-file write request
//   MemW        memory write request
//   Branch      branch request
//   instr_done  pulse on the final cycle of each instruction
//   illegal     pulse when DECODE sees op = 11
//   dbg_state   current state code
// ---------------------------------------------------------------------------
module arm_mc_main_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUop,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               instr_done,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 0,
        S_DECODE   = 1,
        S_MEMADR   = 2,
        S_MEMREAD  = 3,
        S_MEMWB    = 4,
        S_MEMWRITE = 5,
        S_EXECUTER = 6,
        S_EXECUTEI = 7,
        S_ALUWB    = 8,
        S_BRANCH   = 9
    } state_t;

    state_t state_q, state_d;
    logic   mem_ok;

    // funct[4:1] (cmd) is consumed by the ALU decoder, not here.
    logic   unused_cmd;
    assign unused_cmd = ^funct[4:1];

    // With waiting disabled every access is treated as completing at once.
    assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUop      = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        Branch     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ok;
                NextPC    = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b00: state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01: state_d = S_MEMADR;
                    2'b10: state_d = S_BRANCH;
                    default: begin
                        // Undefined instruction ends here, back to fetch.
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegW       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                // The write stays requested for every held cycle.
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                if (mem_ok) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUop   = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUop   = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegW       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                Branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // State is already FETCH during reset, but FETCH would otherwise
        // request IRWrite/NextPC; keep every enable quiet while reset is high.
        if (reset) begin
            IRWrite    = 1'b0;
            NextPC     = 1'b0;
            RegW       = 1'b0;
            MemW       = 1'b0;
            Branch     = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_arm_mc_main_fsm.sv
module tb_arm_mc_main_fsm;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUop;
  logic [1:0] ALUSrcB, ResultSrc;
  logic       RegW, MemW, Branch, instr_done, illegal;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  arm_mc_main_fsm #(.MEM_WAIT_EN(1'b1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUop(ALUop), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .instr_done(instr_done), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Observed output bundle: ir np adr srca srcb[2] res[2] aluop regw memw br done ill
  logic [13:0] obs;
  assign obs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUop,
                RegW, MemW, Branch, instr_done, illegal};
  logic [6:0] obs_en;
  assign obs_en = {IRWrite, NextPC, RegW, MemW, Branch, instr_done, illegal};

  // ---------------- reference model ----------------
  // One entry per expected clock cycle of an instruction: which phase the
  // machine should be in, what mem_ready is driven to, and whether op/funct
  // must carry the real instruction (only in DECODE / MEMADR).
  typedef struct {
    int st;
    bit mr;
    bit real_ins;
  } step_t;

  step_t exp_q[$];

  // Phase codes as listed in the state-code table.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                 P_MEMWB = 4, P_MEMWRITE = 5, P_EXR = 6, P_EXI = 7,
                 P_ALUWB = 8, P_BRANCH = 9;

  // Output table straight from the per-state rules.
  function automatic logic [13:0] exp_out(int st, bit mr, logic [1:0] opc);
    logic ir, np, adr, sa, ao, rw, mw, br, dn, il;
    logic [1:0] sb, rs;
    {ir, np, adr, sa, ao, rw, mw, br, dn, il} = '0;
    sb = 2'b00; rs = 2'b00;
    case (st)
      P_FETCH:    begin sa = 1; sb = 2'b10; rs = 2'b10; ir = mr; np = mr; end
      P_DECODE:   begin sa = 1; sb = 2'b10; rs = 2'b10;
                        if (opc == 2'b11) begin dn = 1; il = 1; end end
      P_MEMADR:   begin sb = 2'b01; end
      P_MEMREAD:  begin adr = 1; end
      P_MEMWB:    begin rs = 2'b01; rw = 1; dn = 1; end
      P_MEMWRITE: begin adr = 1; mw = 1; dn = mr; end
      P_EXR:      begin ao = 1; end
      P_EXI:      begin sb = 2'b01; ao = 1; end
      P_ALUWB:    begin rw = 1; dn = 1; end
      P_BRANCH:   begin sb = 2'b01; rs = 2'b10; br = 1; dn = 1; end
      default:    ;
    endcase
    return {ir, np, adr, sa, sb, rs, ao, rw, mw, br, dn, il};
  endfunction

  // Build the expected cycle sequence for one instruction.
  task automatic build_trace(input logic [1:0] opc, input logic [5:0] fn,
                             input int fst, input int mst);
    exp_q.delete();
    for (int i = 0; i < fst; i++) exp_q.push_back('{P_FETCH, 1'b0, 1'b0});
    exp_q.push_back('{P_FETCH, 1'b1, 1'b0});
    exp_q.push_back('{P_DECODE, 1'($urandom_range(0, 1)), 1'b1});
    case (opc)
      2'b00: begin
        exp_q.push_back('{fn[5] ? P_EXI : P_EXR, 1'($urandom_range(0, 1)), 1'b0});
        exp_q.push_back('{P_ALUWB, 1'($urandom_range(0, 1)), 1'b0});
      end
      2'b01: begin
        exp_q.push_back('{P_MEMADR, 1'($urandom_range(0, 1)), 1'b1});
        for (int i = 0; i < mst; i++)
          exp_q.push_back('{fn[0] ? P_MEMREAD : P_MEMWRITE, 1'b0, 1'b0});
        exp_q.push_back('{fn[0] ? P_MEMREAD : P_MEMWRITE, 1'b1, 1'b0});
        if (fn[0]) exp_q.push_back('{P_MEMWB, 1'($urandom_range(0, 1)), 1'b0});
      end
      2'b10: exp_q.push_back('{P_BRANCH, 1'($urandom_range(0, 1)), 1'b0});
      default: ;
    endcase
  endtask

  // ---------------- driver + per-cycle scoreboard ----------------
  // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 of the
  // cycle after the instruction's last cycle (FETCH again).
  task automatic run_instr(input string name, input logic [1:0] opc,
                           input logic [5:0] fn, input int fst, input int mst);
    int n, done_cnt, ill_cnt, done_at, lat;
    logic [13:0] e;
    build_trace(opc, fn, fst, mst);
    n = exp_q.size();
    done_cnt = 0; ill_cnt = 0; done_at = -1;
    for (int c = 0; c < n; c++) begin
      mem_ready = exp_q[c].mr;
      if (exp_q[c].real_ins) begin
        op = opc; funct = fn;
      end else begin
        op = 2'($urandom_range(0, 3)); funct = 6'($urandom_range(0, 63));
      end
      @(negedge clk);
      checks++;
      if (dbg_state !== exp_q[c].st[3:0]) begin
        errors++;
        $display("FAIL %s state cyc %0d: got %0d exp %0d", name, c, dbg_state, exp_q[c].st);
      end
      e = exp_out(exp_q[c].st, exp_q[c].mr, opc);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s outputs cyc %0d st %0d: got %b exp %b", name, c, exp_q[c].st, obs, e);
      end
      if (instr_done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = c + 1; end
      if (illegal === 1'b1) ill_cnt++;
      @(posedge clk); #1;
    end
    // Latency from the stated cycle counts, independent of the trace.
    case (opc)
      2'b00: lat = 4;
      2'b01: lat = fn[0] ? 5 : 4;
      2'b10: lat = 3;
      default: lat = 2;
    endcase
    lat += fst + ((opc == 2'b01) ? mst : 0);
    checks++;
    if (done_cnt !== 1 || done_at !== lat) begin
      errors++;
      $display("FAIL %s latency: done pulses %0d at cycle %0d exp 1 at %0d", name, done_cnt, done_at, lat);
    end
    checks++;
    if (ill_cnt !== ((opc == 2'b11) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s illegal count: got %0d exp %0d", name, ill_cnt, (opc == 2'b11) ? 1 : 0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; op = 2'b00; funct = 6'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== 4'd0 || obs_en !== 7'd0) begin
        errors++;
        $display("FAIL reset hold cyc %0d: state %0d en %b exp state 0 en 0", i, dbg_state, obs_en);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 4'd0 || IRWrite !== 1'b1 || NextPC !== 1'b1 || ALUSrcB !== 2'b10) begin
      errors++;
      $display("FAIL reset release: state %0d ir %b np %b srcb %b exp 0 1 1 10",
               dbg_state, IRWrite, NextPC, ALUSrcB);
    end
    // Hold in FETCH so the next task starts from a fresh fetch.
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    run_instr("add_reg", 2'b00, 6'b001000, 0, 0);
    run_instr("add_imm", 2'b00, 6'b101001, 0, 0);
  endtask

  task automatic test_ldr_stall();
    run_instr("ldr_stall", 2'b01, 6'b011001, 0, 2);
  endtask

  task automatic test_str_fetch_stall();
    run_instr("str_fstall", 2'b01, 6'b011000, 1, 0);
  endtask

  task automatic test_branch_undef();
    run_instr("branch", 2'b10, 6'b000000, 0, 0);
    run_instr("undef", 2'b11, 6'b000000, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] o;
    logic [5:0] f;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom_range(0, 63));
      run_instr("random", o, f, $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_store();
    op = 2'b01; funct = 6'b000000; mem_ready = 1'b1;
    @(posedge clk); #1;            // DECODE
    @(posedge clk); #1;            // MEMADR
    @(posedge clk); #1;            // MEMWRITE
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 4'd5 || MemW !== 1'b1) begin
      errors++;
      $display("FAIL midreset pre: state %0d memw %b exp 5 1", dbg_state, MemW);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dbg_state !== 4'd0 || obs_en !== 7'd0) begin
      errors++;
      $display("FAIL midreset assert: state %0d en %b exp 0 0", dbg_state, obs_en);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 4'd0 || RegW !== 1'b0 || MemW !== 1'b0 || Branch !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset release: state %0d regw %b memw %b br %b done %b exp 0 0 0 0 0",
               dbg_state, RegW, MemW, Branch, instr_done);
    end
    @(posedge clk); #1;            // stays in FETCH (mem_ready low)
    run_instr("after_reset", 2'b00, 6'b001001, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_stall();
    test_str_fetch_stall();
    test_branch_undef();
    test_back_to_back();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_mc_main_fsm.md
Name: arm_mc_main_fsm

Overview:
- Main-decoder state machine of the multicycle ARM datapath, directly upstream of the ALU decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write enables.
- Drives the ALUop input that the ALU decoder consumes together with funct_cmd/funct_s.
- Adds a memory-ready handshake so fetch and data accesses can stall.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as always 1.
- STATE_W, 4, width of the state register and of dbg_state.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  2  instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 undefined.
- funct  in  6  instr[25:20]: [5] = I (immediate), [4:1] = cmd, [0] = S for data-proc / L for memory.
- mem_ready  in  1  memory has completed the current access this cycle.
- IRWrite  out  1  load instruction register.
- NextPC  out  1  PC update request.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- ALUSrcA  out  1  0 = A register, 1 = PC.
- ALUSrcB  out  2  00 = register WriteData, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUop  out  1  1 = ALU decoder decodes funct_cmd; 0 = forced ADD.
- RegW  out  1  register-file write request.
- MemW  out  1  memory write request.
- Branch  out  1  branch request.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  one-cycle pulse when DECODE sees op = 11.
- dbg_state  out  STATE_W  current state code.

Behaviour:
- Single state register, updated on rising clk. reset forces FETCH immediately (asynchronous).
- While reset is high, every enable output (IRWrite, NextPC, RegW, MemW, Branch, instr_done, illegal) is 0.
- Outputs are combinational from the state, plus mem_ready where noted.
- Unlisted selects are 0; unlisted enables are 0.
- State codes:
  FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BRANCH = 9.
- FETCH:
  - AdrSrc = 0, ALUSrcA = 1, ALUSrcB = 10, ALUop = 0, ResultSrc = 10.
  - IRWrite = NextPC = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - ALUSrcA = 1, ALUSrcB = 10, ALUop = 0, ResultSrc = 10.
  - op 00 → funct[5] ? EXECUTEI : EXECUTER.
  - op 01 → MEMADR.
  - op 10 → BRANCH.
  - op 11 → FETCH, with illegal = 1 and instr_done = 1.
- MEMADR: ALUSrcA = 0, ALUSrcB = 01, ALUop = 0. Goes to funct[0] ? MEMREAD : MEMWRITE.
- MEMREAD:
  - AdrSrc = 1, ResultSrc = 00.
  - Holds until mem_ready = 1, then goes to MEMWB.
- MEMWB: ResultSrc = 01, RegW = 1, instr_done = 1, then FETCH.
- MEMWRITE:
  - AdrSrc = 1, ResultSrc = 00, MemW = 1 on every held cycle.
  - On the cycle mem_ready = 1: instr_done = 1, then FETCH.
- EXECUTER: ALUSrcA = 0, ALUSrcB = 00, ALUop = 1, then ALUWB.
- EXECUTEI: ALUSrcA = 0, ALUSrcB = 01, ALUop = 1, then ALUWB.
- ALUWB: ResultSrc = 00, RegW = 1, instr_done = 1, then FETCH.
- BRANCH: ALUSrcA = 0, ALUSrcB = 01, ALUop = 0, ResultSrc = 10, Branch = 1, instr_done = 1, then FETCH.
- Latency with no stalls:
  - data-proc 4 cycles; load 5; store 4; branch 3; undefined 2.
  - Each mem_ready = 0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Conditional execution and flag updates are outside this block; RegW/MemW/Branch/NextPC are raw requests.
- op/funct are sampled only in DECODE and MEMADR; changes in other states have no effect.
- Unused state codes (10–15): all enables 0, next state FETCH.
- MEM_WAIT_EN = 0: no state ever holds.
- Reset asserted mid-instruction: abandons it with no further RegW/MemW/Branch/instr_done. First cycle after release is FETCH.

Test Plan:
- Reset held 3 cycles then released, mem_ready = 1 → dbg_state = 0 during reset with all enables 0; cycle 1 after release shows IRWrite = NextPC = 1, ALUSrcB = 10.
- op = 00, funct = 6'b001000 (ADD reg), mem_ready = 1 → states 0,1,6,8; ALUop = 1 only in state 6; RegW = 1 and instr_done = 1 only in state 8.
- op = 01, funct[0] = 1 (LDR), mem_ready low 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0; RegW = 1 only in MEMWB; total 7 cycles.
- op = 01, funct[0] = 0 (STR), mem_ready = 0 in FETCH for 1 cycle → IRWrite = 0 during the stall; MemW = 1 in state 5; exactly one instr_done.
- op = 10 then op = 11 → branch: states 0,1,9 with Branch = 1; undefined: states 0,1,0 with illegal = 1 for exactly one cycle.
- Reset asserted while in state 5 with mem_ready = 0 → next observed state 0; MemW drops in the same cycle reset rises.
